seg_bcd_encoder: RTL

- Upstream feeder for the two-digit seven-segment display multiplexer.
- Accepts a binary value 0..99 via a valid/ready handshake and converts it to BCD with an iterative double-dabble over 7 cycles.
- Encodes each BCD digit to a 7-segment pattern and holds both patterns on a registered 14-bit bus that the multiplexer samples continuously.
- Tens pattern is on [13:7]; ones pattern is on [6:0].

---
 rtl/seg_bcd_encoder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/seg_bcd_encoder.sv
// Binary 0..99 to two-digit seven-segment encoder (iterative double-dabble).
// Latency: value accepted at edge T appears on both7seg with out_valid at edge T+8.
// Backpressure: in_ready is high only in IDLE; offers while busy are dropped, not queued.
module seg_bcd_encoder #(
  parameter bit BLANK_LZ   = 1'b1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [6:0]  in_value,
  output logic        in_ready,
  output logic [13:0] both7seg,
  output logic        out_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam logic [13:0] BLANK_PAT = ACTIVE_LOW ? 14'h3FFF : 14'h0000;
  localparam logic [6:0]  SEG_DASH  = 7'h40;
  localparam logic [6:0]  SEG_BLANK = 7'h00;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [6:0]  r_shift;
  logic [3:0]  r_tens;
  logic [3:0]  r_ones;
  logic        r_ovf;
  logic [2:0]  r_cnt;
  logic [13:0] r_seg;
  logic        r_out_vld;

  logic        w_accept;
  logic [3:0]  w_tens_adj;
  logic [3:0]  w_ones_adj;
  logic [14:0] w_dd;
  logic [6:0]  w_tens_seg;
  logic [6:0]  w_ones_seg;
  logic [13:0] w_pat;

  // Segment code for one BCD digit; bit0 = a .. bit6 = g, active-high.
  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'h3F;
      4'd1:    f_seg = 7'h06;
      4'd2:    f_seg = 7'h5B;
      4'd3:    f_seg = 7'h4F;
      4'd4:    f_seg = 7'h66;
      4'd5:    f_seg = 7'h6D;
      4'd6:    f_seg = 7'h7D;
      4'd7:    f_seg = 7'h07;
      4'd8:    f_seg = 7'h7F;
      4'd9:    f_seg = 7'h6F;
      default: f_seg = SEG_BLANK;
    endcase
  endfunction

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == CONV) || (r_state == LOAD);
  assign w_accept  = in_valid && in_ready;
  assign both7seg  = r_seg;
  assign out_valid = r_out_vld;

  // One double-dabble step: add-3 correction on each nibble, then shift left.
  always_comb begin
    w_tens_adj = (r_tens >= 4'd5) ? (r_tens + 4'd3) : r_tens;
    w_ones_adj = (r_ones >= 4'd5) ? (r_ones + 4'd3) : r_ones;
    w_dd       = {w_tens_adj[2:0], w_ones_adj, r_shift, 1'b0};
  end

  // Final display patterns; overflow shows dashes and overrides leading-zero blanking.
  always_comb begin
    w_ones_seg = r_ovf ? SEG_DASH : f_seg(r_ones);
    if (r_ovf) begin
      w_tens_seg = SEG_DASH;
    end else if (BLANK_LZ && (r_tens == 4'd0)) begin
      w_tens_seg = SEG_BLANK;
    end else begin
      w_tens_seg = f_seg(r_tens);
    end
    w_pat = {w_tens_seg, w_ones_seg} ^ {14{ACTIVE_LOW}};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> CONV for 7 iterations -> LOAD for one cycle -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = CONV;
      CONV:    if (r_cnt == 3'd6) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Conversion datapath: capture on accept, iterate in CONV.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_tens  <= '0;
      r_ones  <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_shift <= in_value;
      r_tens  <= '0;
      r_ones  <= '0;
      r_ovf   <= (in_value > 7'd99);
      r_cnt   <= '0;
    end else if (r_state == CONV) begin
      r_tens  <= w_dd[14:11];
      r_ones  <= w_dd[10:7];
      r_shift <= w_dd[6:0];
      r_cnt   <= r_cnt + 3'd1;
    end
  end

  // Output register: updated only when leaving LOAD, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg     <= BLANK_PAT;
      r_out_vld <= 1'b0;
    end else begin
      r_out_vld <= (r_state == LOAD);
      if (r_state == LOAD) begin
        r_seg <= w_pat;
      end
    end
  end

endmodule
